// File: rtl/iddrx2_word_aligner_pkg.sv
// Shared definitions for the IDDRX2 word aligner: FSM state encodings,
// default training word (K28.5 RD-) and the BIT_OFFSET width.
package iddrx2_word_aligner_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } align_state_t;

   // Wide enough for any legal WORD_W; the top truncates to WORD_W.
   localparam logic [15:0] DEF_SYNC_PATTERN = 16'h017C;
   localparam int          OFFSET_W         = 4;

endpackage

// File: rtl/iddrx2_bit_accum.sv
// Bit accumulator: appends 4 gearbox bits per clock behind the held bits
// (time order, oldest in bit 0), optionally drops the oldest held bit, and
// emits the oldest WORD_W bits once enough are held.
// Ports:
//   clk, rst  clock, synchronous active-high reset (drops held bits)
//   din[3:0]  new bits, din[0] oldest
//   slip      discard the oldest held bit this cycle
//   emit      a word completes this cycle (combinational)
//   word      the completed word, first bit in word[0] (valid with emit)
module iddrx2_bit_accum #(
   parameter int WORD_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        din,
   input  logic              slip,
   output logic              emit,
   output logic [WORD_W-1:0] word
);

   localparam int BUF_W = WORD_W + 4;
   localparam int CNT_W = $clog2(BUF_W + 1);

   // Bits above cnt_q are always zero, so new bits can simply be OR-ed in.
   logic [BUF_W-1:0] acc_q, acc_d, merged;
   logic [CNT_W-1:0] cnt_q, cnt_d, post_cnt;

   always_comb begin
      merged   = acc_q | (BUF_W'(din) << cnt_q);
      post_cnt = cnt_q + CNT_W'(4);
      if (slip) begin
         merged   = merged >> 1;
         post_cnt = post_cnt - CNT_W'(1);
      end
      emit  = (post_cnt >= CNT_W'(WORD_W));
      word  = merged[WORD_W-1:0];
      acc_d = merged;
      cnt_d = post_cnt;
      if (emit) begin
         acc_d = merged >> WORD_W;
         cnt_d = post_cnt - CNT_W'(WORD_W);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iddrx2_word_aligner.sv
// SCLK-domain word aligner behind the ECP3 IDDRX2D1 gearbox. Packs 4 bits
// per SCLK into WORD_W-bit words and finds word alignment by bit-slip
// against a training word (or its complement).
// Ports:
//   SCLK, RST            clock, synchronous active-high reset
//   QA0,QB0,QA1,QB1      gearbox bits, serial order QA0 (oldest)..QB1
//   ALIGN_EN             1 = alignment FSM runs, 0 = FSM frozen
//   RETRAIN              one-cycle pulse: drop lock, restart search
//   DOUT, DOUT_VALID     aligned word (first bit in DOUT[0]) and strobe
//   LOCKED               alignment achieved
//   BIT_OFFSET           total slips applied, modulo WORD_W
module iddrx2_word_aligner
   import iddrx2_word_aligner_pkg::*;
#(
   parameter int                WORD_W       = 10,
   parameter logic [WORD_W-1:0] SYNC_PATTERN = WORD_W'(DEF_SYNC_PATTERN),
   parameter int                LOCK_COUNT   = 4
) (
   input  logic                SCLK,
   input  logic                RST,
   input  logic                QA0,
   input  logic                QB0,
   input  logic                QA1,
   input  logic                QB1,
   input  logic                ALIGN_EN,
   input  logic                RETRAIN,
   output logic [WORD_W-1:0]   DOUT,
   output logic                DOUT_VALID,
   output logic                LOCKED,
   output logic [OFFSET_W-1:0] BIT_OFFSET
);

   align_state_t        state_q, state_d;
   logic [3:0]          match_q, match_d, match_inc;
   logic                slip_q, slip_d;
   logic [OFFSET_W-1:0] off_d;
   logic                emit, is_match;
   logic [WORD_W-1:0]   word;

   iddrx2_bit_accum #(.WORD_W(WORD_W)) u_accum (
      .clk  (SCLK),
      .rst  (RST),
      .din  ({QB1, QA1, QB0, QA0}),
      .slip (slip_q),
      .emit (emit),
      .word (word)
   );

   assign is_match  = (word == SYNC_PATTERN) || (word == ~SYNC_PATTERN);
   assign match_inc = match_q + 4'd1;

   // Decisions are made on the word as it is emitted, so state, slip and
   // DOUT all update on the same edge; the slip takes effect one cycle later.
   always_comb begin
      state_d = state_q;
      match_d = match_q;
      slip_d  = 1'b0;
      off_d   = BIT_OFFSET;
      if (RETRAIN) begin
         // Overrides any mismatch-slip from the same cycle.
         state_d = ST_SEARCH;
         match_d = '0;
      end else if (ALIGN_EN && emit && state_q != ST_LOCKED) begin
         if (is_match) begin
            match_d = match_inc;
            state_d = (match_inc == 4'(LOCK_COUNT)) ? ST_LOCKED : ST_VERIFY;
         end else begin
            state_d = ST_SEARCH;
            match_d = '0;
            slip_d  = 1'b1;
            off_d   = (BIT_OFFSET == OFFSET_W'(WORD_W - 1)) ? '0
                                                            : BIT_OFFSET + OFFSET_W'(1);
         end
      end
   end

   always_ff @(posedge SCLK) begin
      if (RST) begin
         state_q    <= ST_SEARCH;
         match_q    <= '0;
         slip_q     <= 1'b0;
         BIT_OFFSET <= '0;
         DOUT       <= '0;
         DOUT_VALID <= 1'b0;
      end else begin
         state_q    <= state_d;
         match_q    <= match_d;
         slip_q     <= slip_d;
         BIT_OFFSET <= off_d;
         DOUT_VALID <= emit;
         if (emit) DOUT <= word;
      end
   end

   assign LOCKED = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_iddrx2_word_aligner.sv
module tb_iddrx2_word_aligner;

   localparam int W    = 10;
   localparam int LOCK = 4;

   logic         sclk = 1'b0;
   logic         rst = 1'b1, en = 1'b1, rt = 1'b0;
   logic         qa0 = 1'b0, qb0 = 1'b0, qa1 = 1'b0, qb1 = 1'b0;
   logic [W-1:0] dout;
   logic         dout_valid, locked;
   logic [3:0]   bit_offset;

   int passed = 0;
   int total  = 0;

   always #5 sclk = ~sclk;

   iddrx2_word_aligner dut (
      .SCLK(sclk), .RST(rst), .QA0(qa0), .QB0(qb0), .QA1(qa1), .QB1(qb1),
      .ALIGN_EN(en), .RETRAIN(rt), .DOUT(dout), .DOUT_VALID(dout_valid),
      .LOCKED(locked), .BIT_OFFSET(bit_offset)
   );

   // Transmit bit stream, oldest first; refilled with random bits when empty.
   bit txq[$];

   // Reference model: the serial stream as a queue of bits plus a plain
   // search/verify/locked bookkeeping in integers.
   bit           mq[$];
   int           m_state;   // 0 search, 1 verify, 2 locked
   int           m_mc, m_off;
   bit           m_slip, m_valid;
   logic [W-1:0] m_dout;
   logic [W-1:0] sync_w = 10'h17C;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) txq.push_back(w[i]);
   endtask

   task automatic model_step(input logic [3:0] d);
      logic [W-1:0] w;
      bit           em;
      if (rst) begin
         mq.delete();
         m_state = 0; m_mc = 0; m_off = 0; m_slip = 0; m_valid = 0; m_dout = '0;
         return;
      end
      for (int i = 0; i < 4; i++) mq.push_back(d[i]);
      if (m_slip) void'(mq.pop_front());
      m_slip = 0;
      em = (mq.size() >= W);
      w  = '0;
      if (em) begin
         for (int i = 0; i < W; i++) w[i] = mq.pop_front();
         m_dout = w;
      end
      m_valid = em;
      if (rt) begin
         m_state = 0; m_mc = 0;
      end else if (en && em && m_state != 2) begin
         if (w == sync_w || w == ~sync_w) begin
            m_mc++;
            m_state = (m_mc >= LOCK) ? 2 : 1;
         end else begin
            m_state = 0; m_mc = 0; m_slip = 1;
            m_off = (m_off + 1) % W;
         end
      end
   endtask

   // One clock: drive 4 stream bits, clock, advance model, compare.
   task automatic cyc();
      logic [3:0] d;
      d = 4'($urandom);
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (txq.size() == 0) txq.push_back(1'($urandom));
            d[i] = txq.pop_front();
         end
      end
      {qb1, qa1, qb0, qa0} = d;
      @(posedge sclk);
      model_step(d);
      #1;
      chk("valid", dout_valid, m_valid);
      chk("dout", dout, m_dout);
      chk("locked", locked, m_state == 2);
      chk("offset", bit_offset, m_off);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) cyc();
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_offset", bit_offset, 0);
      txq.delete();
      rst = 1'b0;
   endtask

   initial begin
      int n, nv, off_before;
      logic [W-1:0] k, kn, bad;
      k = 10'h17C; kn = ~k; bad = k ^ 10'h001;

      // 1: reset mid-stream, first strobe latency
      rst = 1'b1; cyc();
      rst = 1'b0;
      repeat (7) cyc();
      do_reset();
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(); n++;
         if (dout_valid) break;
      end
      chk("first_valid_lat", n, 3);

      // 2: aligned K28.5 stream locks on the 4th word, no slips
      do_reset();
      repeat (30) push_word(k);
      nv = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (dout_valid) nv++;
         if (locked) break;
      end
      chk("t2_valids_at_lock", nv, 4);
      chk("t2_locked", locked, 1);
      chk("t2_dout", dout, k);
      chk("t2_offset", bit_offset, 0);

      // 3: stream delayed by 3 bits needs exactly 3 slips
      do_reset();
      repeat (3) txq.push_back(1'b0);
      repeat (50) push_word(k);
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (locked) break;
      end
      chk("t3_locked", locked, 1);
      chk("t3_offset", bit_offset, 3);

      // 4: alternating RD-/RD+, one corrupted word while verifying
      do_reset();
      push_word(k); push_word(kn); push_word(bad);
      repeat (40) begin push_word(k); push_word(kn); end
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (dout_valid && dout == bad) break;
      end
      chk("t4_bad_seen", dout, bad);
      chk("t4_bad_offset", bit_offset, 1);
      chk("t4_bad_unlocked", locked, 0);
      for (int i = 0; i < 150; i++) begin
         cyc();
         if (locked) break;
      end
      chk("t4_relock", locked, 1);

      // 5: random data while locked, then RETRAIN on an emitting cycle
      txq.delete();
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("t5_hold_lock", locked, 1);
      end
      off_before = m_off;
      for (int i = 0; i < 10; i++) begin
         if (mq.size() + 4 >= W) begin
            rt = 1'b1; cyc(); rt = 1'b0;
            break;
         end
         cyc();
      end
      chk("t5_retrain_unlocked", locked, 0);
      chk("t5_retrain_offset", bit_offset, off_before);
      cyc();
      chk("t5_no_slip", bit_offset, off_before);

      // 6: ALIGN_EN=0 freezes search, cadence 2 words per 5 cycles
      en = 1'b0;
      do_reset();
      txq.push_back(1'b1); txq.push_back(1'b0); txq.push_back(1'b1);
      txq.push_back(1'b0); txq.push_back(1'b1);
      repeat (60) push_word(k);
      nv = 0;
      for (int i = 0; i < 25; i++) begin
         cyc();
         if (dout_valid) nv++;
      end
      chk("t6_cadence", nv, 10);
      chk("t6_no_slip", bit_offset, 0);
      chk("t6_unlocked", locked, 0);
      en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         cyc();
         if (locked) break;
      end
      chk("t6_locked", locked, 1);
      chk("t6_offset", bit_offset, 5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
